// File: rtl/vga_frame_capture.sv
// Captures one VGA frame (or a continuous stream of frames) into a linear framebuffer.
// Pixels are written one cycle after they are sampled, at an address driven by a counter.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              continuous,
  input  logic              blank_n,
  input  logic              VS,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);

  localparam logic [COL_W-1:0]  ColMax  = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LineMax = LINE_W'(V_ACTIVE);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vs_prev_q;
  logic              blank_prev_q;

  logic vs_start;
  logic line_end;

  assign vs_start = ~VS & vs_prev_q;
  assign line_end = ~blank_n & blank_prev_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StArmed;
          err_d   = 1'b0;
        end
      end

      // An edge coincident with arm was seen in StIdle, so it never reaches here.
      StArmed: begin
        if (vs_start) begin
          state_d = StCapture;
          col_d   = '0;
          line_d  = '0;
          addr_d  = '0;
        end
      end

      StCapture: begin
        if (vs_start) begin
          done_d  = 1'b1;
          if (line_q != LineMax) err_d = 1'b1;
          col_d   = '0;
          line_d  = '0;
          addr_d  = '0;
          state_d = continuous ? StCapture : StIdle;
        end else if (line_end) begin
          if (col_q != ColMax) err_d = 1'b1;
          if (line_q != LineMax) line_d = line_q + 1'b1;
          col_d = '0;
        end else if (blank_n) begin
          if ((col_q < ColMax) && (line_q < LineMax)) begin
            we_d      = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {red, green, blue};
            addr_d    = addr_q + 1'b1;
            col_d     = col_q + 1'b1;
          end else begin
            // Overrun or extra line: pixel dropped, col stays saturated.
            err_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      vs_prev_q    <= 1'b1;
      blank_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      done_q       <= done_d;
      err_q        <= err_d;
      vs_prev_q    <= VS;
      blank_prev_q <= blank_n;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign we         = we_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed vector bench for vga_frame_capture with a 4x3 active area.
// Each record holds the inputs for one cycle and the outputs expected just after that edge.
module tb_vga_frame_capture;

  logic        vga_clk = 1'b0;
  logic        reset, arm, continuous, blank_n, VS;
  logic [7:0]  red, green, blue;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        we, busy, frame_done, frame_err;

  vga_frame_capture #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .ADDR_W   (19)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .arm        (arm),
    .continuous (continuous),
    .blank_n    (blank_n),
    .VS         (VS),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       tag;
    logic        rst, a, c, bn, vs;
    logic [23:0] rgb;
    logic        xwe;
    logic [18:0] xaddr;
    logic [23:0] xdata;
    logic        xbusy, xdone, xerr;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;
  string       cur_tag = "";
  logic [18:0] hold_addr = '0;
  logic [23:0] hold_data = '0;

  // Expected wr_addr/wr_data follow the last write and hold otherwise.
  task automatic add(input logic rst, a, c, bn, vs, input logic [23:0] rgb,
                     input logic xwe, input logic [18:0] waddr,
                     input logic xbusy, xdone, xerr);
    vec_t v;
    if (rst) begin
      hold_addr = '0;
      hold_data = '0;
    end else if (xwe) begin
      hold_addr = waddr;
      hold_data = rgb;
    end
    v.tag = cur_tag; v.rst = rst; v.a = a; v.c = c; v.bn = bn; v.vs = vs; v.rgb = rgb;
    v.xwe = xwe; v.xaddr = hold_addr; v.xdata = hold_data;
    v.xbusy = xbusy; v.xdone = xdone; v.xerr = xerr;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic c, vs, xbusy, xdone, xerr);
    add(1'b0, 1'b0, c, 1'b0, vs, 24'h0, 1'b0, 19'h0, xbusy, xdone, xerr);
  endtask

  task automatic start(input logic c, input logic err_before);
    idle(c, 1'b1, 1'b0, 1'b0, err_before);
    add(1'b0, 1'b1, c, 1'b0, 1'b1, 24'h0, 1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
    idle(c, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(c, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lines(input int first, input int n, input logic c, input logic xerr);
    for (int l = first; l < first + n; l++) begin
      for (int col = 0; col < 4; col++)
        add(1'b0, 1'b0, c, 1'b1, 1'b1, 24'(l * 4 + col), 1'b1, 19'(l * 4 + col),
            1'b1, 1'b0, xerr);
      idle(c, 1'b1, 1'b1, 1'b0, xerr);
      idle(c, 1'b1, 1'b1, 1'b0, xerr);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge vga_clk);
    reset = v.rst; arm = v.a; continuous = v.c; blank_n = v.bn; VS = v.vs;
    {red, green, blue} = v.rgb;
    @(posedge vga_clk);
    #1;
    n_vec++;
    if (we !== v.xwe || wr_addr !== v.xaddr || wr_data !== v.xdata || busy !== v.xbusy ||
        frame_done !== v.xdone || frame_err !== v.xerr) begin
      n_bad++;
      $display("FAIL %s vec %0d: got we=%b addr=%0d data=%h busy=%b done=%b err=%b, want we=%b addr=%0d data=%h busy=%b done=%b err=%b",
               v.tag, n_vec, we, wr_addr, wr_data, busy, frame_done, frame_err,
               v.xwe, v.xaddr, v.xdata, v.xbusy, v.xdone, v.xerr);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; continuous = 1'b0; blank_n = 1'b0; VS = 1'b1;
    red = '0; green = '0; blue = '0;

    cur_tag = "reset";
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    cur_tag = "full_frame";
    start(1'b0, 1'b0);
    lines(0, 3, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    cur_tag = "overrun";
    start(1'b0, 1'b0);
    for (int col = 0; col < 4; col++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'(col), 1'b1, 19'(col), 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 19'h0, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    lines(1, 2, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    cur_tag = "short_frame";
    start(1'b0, 1'b1);
    lines(0, 2, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    cur_tag = "continuous";
    start(1'b1, 1'b1);
    lines(0, 3, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    lines(0, 3, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table();

    // Reset mid-capture, then a whole frame with no arm must produce no writes.
    cur_tag = "reset_mid";
    start(1'b0, 1'b0);
    lines(0, 1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd4, 1'b1, 19'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd5, 1'b1, 19'd5, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int col = 0; col < 4; col++)
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'(l * 4 + col), 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table();

    // Arm in the same cycle as a VS edge: that frame is skipped, the next one captured.
    cur_tag = "arm_on_vs";
    idle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int col = 0; col < 4; col++)
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h00AA00, 1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lines(0, 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 600: active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19: framebuffer write-address width.
REQ-004 SHALL have port vga_clk  input  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port arm  input  1: single-cycle request to capture the next frame.
REQ-007 SHALL have port continuous  input  1: 1 = re-arm automatically after each frame.
REQ-008 SHALL have port blank_n  input  1: 1 = incoming pixel is in the active region.
REQ-009 SHALL have port VS  input  1: vertical sync, active low.
REQ-010 SHALL have ports red, green, blue  input  8 each: incoming pixel colour.
REQ-011 SHALL have port wr_addr  output  ADDR_W: framebuffer write address.
REQ-012 SHALL have port wr_data  output  24: {red, green, blue} of the written pixel.
REQ-013 SHALL have port we  output  1: framebuffer write strobe, one pixel per cycle.
REQ-014 SHALL have port busy  output  1: high in ARMED or CAPTURE.
REQ-015 SHALL have port frame_done  output  1: one-cycle pulse at frame end.
REQ-016 SHALL have port frame_err  output  1: sticky geometry-error flag.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE.
REQ-018 SHALL detect a VS start edge as VS==0 while the registered previous VS==1.
REQ-019 SHALL detect a line end as blank_n==0 while the registered previous blank_n==1.
REQ-020 SHALL move IDLE->ARMED on arm==1; SHALL clear frame_err on this transition.
REQ-021 SHALL ignore arm in ARMED and in CAPTURE.
REQ-022 SHALL not treat a VS edge in the same cycle as an accepted arm as a frame start.
REQ-023 SHALL move ARMED->CAPTURE on a VS start edge and zero the column counter, line counter and address.
REQ-024 SHALL, in CAPTURE, for each cycle with blank_n==1, col<H_ACTIVE and line<V_ACTIVE, assert we on the next cycle with wr_data={red,green,blue} sampled that cycle and wr_addr=line*H_ACTIVE+col. Latency is exactly 1 cycle.
REQ-025 SHALL compute the address with an incrementing counter and no multiplier; it SHALL advance by 1 per accepted pixel.
REQ-026 SHALL suppress we for pixels with col>=H_ACTIVE (overrun) or line>=V_ACTIVE, and SHALL set frame_err.
REQ-027 SHALL, on a line end in CAPTURE, set frame_err if col!=H_ACTIVE, increment line (saturating at V_ACTIVE), and zero col.
REQ-028 SHALL, on a VS start edge in CAPTURE, pulse frame_done for one cycle and set frame_err if line!=V_ACTIVE.
REQ-029 SHALL, at that frame end, go to CAPTURE with counters and address zeroed if continuous==1, else go to IDLE.
REQ-030 SHALL hold we low in IDLE and ARMED. wr_addr and wr_data SHALL hold their last values when we==0.
REQ-031 SHALL keep frame_err set until reset or the next accepted arm.

Reset
REQ-032 SHALL on reset: state=IDLE, we=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, counters=0, previous VS=1, previous blank_n=0.
REQ-033 SHALL abandon any capture in progress on reset. No further we SHALL occur until a new arm and VS start edge.

Verification (H_ACTIVE=4, V_ACTIVE=3)
REQ-034 Bench SHALL cover: arm, VS edge, 3 lines of 4 pixels with data=addr, then VS edge -> 12 writes at addr 0..11 with matching data, one frame_done, frame_err=0, busy=0 afterwards.
REQ-035 Bench SHALL cover: a 5-pixel line -> only 4 writes for that line, fifth pixel dropped, frame_err=1 at frame_done.
REQ-036 Bench SHALL cover: a 2-line frame -> 8 writes, frame_done pulse, frame_err=1.
REQ-037 Bench SHALL cover: continuous=1 over two frames -> addresses 0..11 twice, two frame_done pulses, busy held high.
REQ-038 Bench SHALL cover: reset after 6 pixels -> we=0 from the next cycle, state IDLE; frame pixels with no arm -> no writes.
REQ-039 Bench SHALL cover: arm coincident with a VS edge -> no capture of that frame; capture starts at the following VS edge.
